fwd_transform4x4: RTL and testbench
===================================

// Module: fwd_transform4x4
// PURPOSE
//  Forward 4x4 integer core transform stage, directly downstream of intra prediction.
//  Consumes the winning 4x4 luma residual block and its mode from the SAD stage.
//  Computes Y = C*X*C^T, C = {1,1,1,1; 2,1,-1,-2; 1,-1,-1,1; 1,-2,2,-1}:
//  a row pass then a column pass, one row/column per cycle, with valid/ready on both sides.
// PARAMETERS
//  IN_WIDTH   8   signed residual width (two's complement)
//  MID_WIDTH  11  signed row-pass intermediate width (IN_WIDTH+3)
//  OUT_WIDTH  16  signed coefficient width; legal 8..16
// PORTS
//  clk        in   1              single clock, rising edge
//  reset      in   1              synchronous, active-high
//  enable     in   1              0 = freeze all state, outputs hold
//  in_valid   in   1              residual block + mode valid
//  in_ready   out  1              stage can accept a block
//  res_in     in   [15:0][IN_W]   signed residuals, index 4*row+col
//  mode_in    in   3              prediction mode of block
//  out_valid  out  1              coefficients valid
//  out_ready  in   1              consumer accepts coefficients
//  coeff      out  [15:0][OUT_W]  signed coefficients, index 4*i+j
//  mode_out   out  3              mode of block on coeff
// BEHAVIOUR
//  Reset: state=IDLE; in_ready=1; out_valid=0; coeff[*]=0; mode_out=0; counters=0.
//  Synchronous reset wins over everything; an in-flight block is discarded.
//  FSM (advances only when enable=1; enable=0 holds state, counters, registers, outputs):
//   IDLE: in_ready=1. in_valid&in_ready -> latch res_in, mode_in; cnt=0; ->ROW.
//   ROW : in_ready=0. Per cycle, row r=cnt: T[r][j] = sum_c X[r][c]*C[j][c], stored MID_WIDTH.
//         cnt 3 -> cnt=0, ->COL.
//   COL : per cycle, column j=cnt: Y[i][j] = sum_r C[i][r]*T[r][j] into coeff reg.
//         cnt 3 -> out_valid=1, mode_out=latched mode, ->DONE.
//   DONE: hold out_valid, coeff, mode_out stable until out_valid&out_ready, then
//         out_valid=0 and ->IDLE. in_ready stays 0 in DONE.
//  Latency (enable=1): acceptance edge E; ROW on E+1..E+4; COL on E+5..E+8;
//   out_valid high after E+8. Minimum 10 cycles per block.
//  Arithmetic: multiplies by 2 are shifts; full-precision sums; |T|<=6*2^(IN_WIDTH-1)
//   fits MID_WIDTH. Column result is 14 bits for IN_WIDTH=8, sign-extended to OUT_WIDTH.
//   When OUT_WIDTH<14, narrowing is governed by FT_SATURATE_EN.
//  in_valid while in_ready=0 is ignored; upstream holds it. res_in is sampled only at acceptance.
//  coeff changes only on the COL edges and on reset; it is never cleared on handshake.
// CONFIGURATION
//  FT_SATURATE_EN defined: each coefficient is clamped to
//   [-2^(OUT_WIDTH-1), 2^(OUT_WIDTH-1)-1] before it is registered.
//  FT_SATURATE_EN undefined: the low OUT_WIDTH bits are kept (two's-complement wrap).
//  With OUT_WIDTH>=14 both builds are bit-identical.
// TESTING
//  1 all res_in=0 -> coeff all 0, out_valid 8 cycles after acceptance, mode_out=mode_in.
//  2 all res_in=1 -> coeff[0]=16, all others 0.
//  3 res_in[0]=1, rest 0 -> coeff rows {1,2,1,1},{2,4,2,2},{1,2,1,1},{1,2,1,1}.
//  4 all res_in=-128 -> coeff[0]=-2048, rest 0.
//  5 all res_in=127, OUT_WIDTH=11 -> coeff[0]=1023 with FT_SATURATE_EN; -16 without it.
//  6 out_ready=0 for 5 cycles in DONE -> coeff/out_valid held, in_ready=0; enable=0 in ROW
//    -> latency grows by the stalled cycles; reset in COL -> IDLE, out_valid=0, coeff=0.

Source files
------------

// File: rtl/fwd_transform4x4.sv
// Forward 4x4 integer core transform (Y = C*X*C^T): a row pass, then a column pass, one per cycle.
// Define FT_SATURATE_EN to clamp coefficients to OUT_WIDTH instead of two's-complement wrapping.
module fwd_transform4x4 #(
    parameter int IN_WIDTH  = 8,
    parameter int MID_WIDTH = 11,
    parameter int OUT_WIDTH = 16
) (
    input  logic                             clk,
    input  logic                             reset,
    input  logic                             enable,
    input  logic                             in_valid,
    output logic                             in_ready,
    input  logic [15:0][IN_WIDTH-1:0]        res_in,
    input  logic [2:0]                       mode_in,
    output logic                             out_valid,
    input  logic                             out_ready,
    output logic [15:0][OUT_WIDTH-1:0]       coeff,
    output logic [2:0]                       mode_out
);

    localparam int SUM_W  = MID_WIDTH + 3;
    localparam int WIDE_W = (OUT_WIDTH > SUM_W) ? OUT_WIDTH : SUM_W;

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_ROW  = 2'd1;
    localparam logic [1:0] S_COL  = 2'd2;
    localparam logic [1:0] S_DONE = 2'd3;

`ifdef FT_SATURATE_EN
    localparam logic signed [WIDE_W-1:0] SAT_MAX =
        {{(WIDE_W-OUT_WIDTH+1){1'b0}}, {(OUT_WIDTH-1){1'b1}}};
    localparam logic signed [WIDE_W-1:0] SAT_MIN =
        {{(WIDE_W-OUT_WIDTH+1){1'b1}}, {(OUT_WIDTH-1){1'b0}}};
`endif

    logic [1:0]                     state_q, state_d;
    logic [1:0]                     cnt_q, cnt_d;
    logic [15:0][IN_WIDTH-1:0]      x_q, x_d;
    logic [2:0]                     mode_q, mode_d;
    logic [15:0][MID_WIDTH-1:0]     t_q, t_d;
    logic [15:0][OUT_WIDTH-1:0]     coeff_q, coeff_d;
    logic [2:0]                     mode_out_q, mode_out_d;
    logic                           out_valid_q, out_valid_d;

    logic signed [MID_WIDTH-1:0]    xa [4];
    logic signed [MID_WIDTH-1:0]    rt [4];
    logic signed [WIDE_W-1:0]       tc [4];
    logic signed [WIDE_W-1:0]       yc [4];

    // Narrowing is a no-op whenever OUT_WIDTH covers the full column-sum width.
    function automatic logic [OUT_WIDTH-1:0] narrow(input logic signed [WIDE_W-1:0] v);
        logic signed [WIDE_W-1:0] c;
`ifdef FT_SATURATE_EN
        if (v > SAT_MAX) begin
            c = SAT_MAX;
        end else if (v < SAT_MIN) begin
            c = SAT_MIN;
        end else begin
            c = v;
        end
`else
        c = v;
`endif
        return c[OUT_WIDTH-1:0];
    endfunction

    always_comb begin
        for (int unsigned c = 0; c < 4; c++) begin
            xa[c] = MID_WIDTH'($signed(x_q[{cnt_q, 2'(c)}]));
        end
        rt[0] = xa[0] + xa[1] + xa[2] + xa[3];
        rt[1] = (xa[0] <<< 1) + xa[1] - xa[2] - (xa[3] <<< 1);
        rt[2] = xa[0] - xa[1] - xa[2] + xa[3];
        rt[3] = xa[0] - (xa[1] <<< 1) + (xa[2] <<< 1) - xa[3];
    end

    always_comb begin
        for (int unsigned r = 0; r < 4; r++) begin
            tc[r] = WIDE_W'($signed(t_q[{2'(r), cnt_q}]));
        end
        yc[0] = tc[0] + tc[1] + tc[2] + tc[3];
        yc[1] = (tc[0] <<< 1) + tc[1] - tc[2] - (tc[3] <<< 1);
        yc[2] = tc[0] - tc[1] - tc[2] + tc[3];
        yc[3] = tc[0] - (tc[1] <<< 1) + (tc[2] <<< 1) - tc[3];
    end

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        x_d         = x_q;
        mode_d      = mode_q;
        t_d         = t_q;
        coeff_d     = coeff_q;
        mode_out_d  = mode_out_q;
        out_valid_d = out_valid_q;
        if (enable) begin
            case (state_q)
                S_IDLE: begin
                    if (in_valid) begin
                        x_d     = res_in;
                        mode_d  = mode_in;
                        cnt_d   = 2'd0;
                        state_d = S_ROW;
                    end
                end
                S_ROW: begin
                    for (int unsigned j = 0; j < 4; j++) begin
                        t_d[{cnt_q, 2'(j)}] = rt[j];
                    end
                    cnt_d = cnt_q + 2'd1;
                    if (cnt_q == 2'd3) begin
                        state_d = S_COL;
                    end
                end
                S_COL: begin
                    for (int unsigned i = 0; i < 4; i++) begin
                        coeff_d[{2'(i), cnt_q}] = narrow(yc[i]);
                    end
                    cnt_d = cnt_q + 2'd1;
                    if (cnt_q == 2'd3) begin
                        out_valid_d = 1'b1;
                        mode_out_d  = mode_q;
                        state_d     = S_DONE;
                    end
                end
                S_DONE: begin
                    if (out_ready) begin
                        out_valid_d = 1'b0;
                        state_d     = S_IDLE;
                    end
                end
                default: state_d = S_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= S_IDLE;
            cnt_q       <= '0;
            x_q         <= '0;
            mode_q      <= '0;
            t_q         <= '0;
            coeff_q     <= '0;
            mode_out_q  <= '0;
            out_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            x_q         <= x_d;
            mode_q      <= mode_d;
            t_q         <= t_d;
            coeff_q     <= coeff_d;
            mode_out_q  <= mode_out_d;
            out_valid_q <= out_valid_d;
        end
    end

    assign in_ready  = (state_q == S_IDLE);
    assign out_valid = out_valid_q;
    assign coeff     = coeff_q;
    assign mode_out  = mode_out_q;

endmodule

// File: tb/tb_fwd_transform4x4.sv
// Randomized bench for fwd_transform4x4: a 16-bit and an 11-bit output instance against a matrix model.
module tb_fwd_transform4x4;

    typedef int blk_t [16];

    logic                  clk = 1'b0;
    logic                  reset, enable, in_valid, out_ready;
    logic [15:0][7:0]      res_in;
    logic [2:0]            mode_in;
    logic                  ir16, ov16, ir11, ov11;
    logic [15:0][15:0]     co16;
    logic [15:0][10:0]     co11;
    logic [2:0]            mo16, mo11;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    fwd_transform4x4 #(.IN_WIDTH(8), .MID_WIDTH(11), .OUT_WIDTH(16)) u_dut (
        .clk(clk), .reset(reset), .enable(enable), .in_valid(in_valid), .in_ready(ir16),
        .res_in(res_in), .mode_in(mode_in), .out_valid(ov16), .out_ready(out_ready),
        .coeff(co16), .mode_out(mo16)
    );

    fwd_transform4x4 #(.IN_WIDTH(8), .MID_WIDTH(11), .OUT_WIDTH(11)) u_dut_n (
        .clk(clk), .reset(reset), .enable(enable), .in_valid(in_valid), .in_ready(ir11),
        .res_in(res_in), .mode_in(mode_in), .out_valid(ov11), .out_ready(out_ready),
        .coeff(co11), .mode_out(mo11)
    );

    task automatic chk(input string tag, input logic signed [31:0] obs, input logic signed [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s obs=%0d exp=%0d", tag, obs, exp);
        end
    endtask

    function automatic blk_t transform(blk_t x);
        int cm [4][4] = '{'{1, 1, 1, 1}, '{2, 1, -1, -2}, '{1, -1, -1, 1}, '{1, -2, 2, -1}};
        blk_t y;
        for (int i = 0; i < 4; i++)
            for (int j = 0; j < 4; j++) begin
                y[4*i+j] = 0;
                for (int r = 0; r < 4; r++)
                    for (int c = 0; c < 4; c++)
                        y[4*i+j] += cm[i][r] * x[4*r+c] * cm[j][c];
            end
        return y;
    endfunction

    function automatic int narrow(int v, int w);
`ifdef FT_SATURATE_EN
        int hi = (1 << (w-1)) - 1;
        int lo = -(1 << (w-1));
        return (v > hi) ? hi : ((v < lo) ? lo : v);
`else
        int m = 1 << w;
        int r = v & (m - 1);
        if (r >= m/2) r -= m;
        return r;
`endif
    endfunction

    task automatic present(input blk_t x, input int mode);
        for (int k = 0; k < 16; k++) res_in[k] = 8'(x[k]);
        mode_in  = 3'(mode);
        in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        res_in   = {$urandom, $urandom, $urandom, $urandom};
        mode_in  = 3'($urandom);
    endtask

    task automatic run_block(input blk_t x, input int mode, input int row_stall,
                             input int done_stall, input string tag);
        blk_t y;
        int lat;
        y = transform(x);
        chk({tag, "/in_ready_idle"}, ir16, 1);
        present(x, mode);
        lat = 0;
        while (!ov16 && lat < 60) begin
            enable = !(lat >= 2 && lat < 2 + row_stall);
            if (lat == 1) chk({tag, "/in_ready_busy"}, ir16, 0);
            @(negedge clk);
            lat++;
        end
        enable = 1'b1;
        chk({tag, "/latency"}, lat, 8 + row_stall);
        chk({tag, "/out_valid_n"}, ov11, 1);
        for (int k = 0; k < 16; k++) begin
            chk({tag, "/coeff16"}, $signed(co16[k]), narrow(y[k], 16));
            chk({tag, "/coeff11"}, $signed(co11[k]), narrow(y[k], 11));
        end
        chk({tag, "/mode_out"}, mo16, mode);
        chk({tag, "/mode_out_n"}, mo11, mode);
        out_ready = 1'b0;
        repeat (done_stall) @(negedge clk);
        chk({tag, "/hold_valid"}, ov16, 1);
        chk({tag, "/hold_in_ready"}, ir16, 0);
        chk({tag, "/hold_coeff"}, $signed(co16[0]), narrow(y[0], 16));
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        chk({tag, "/valid_drop"}, ov16, 0);
        chk({tag, "/ready_back"}, ir16, 1);
        chk({tag, "/coeff_kept"}, $signed(co16[5]), narrow(y[5], 16));
    endtask

    function automatic blk_t fill(int v);
        blk_t x;
        for (int k = 0; k < 16; k++) x[k] = v;
        return x;
    endfunction

    function automatic blk_t rand_blk();
        blk_t x;
        int kind = int'($urandom_range(0, 3));
        int cval = int'($urandom_range(0, 255)) - 128;
        for (int k = 0; k < 16; k++) begin
            case (kind)
                0: x[k] = int'($urandom_range(0, 255)) - 128;
                1: x[k] = $urandom_range(0, 1) ? 127 : -128;
                2: x[k] = int'($urandom_range(0, 8)) - 4;
                default: x[k] = cval;
            endcase
        end
        return x;
    endfunction

    initial begin
        blk_t x;
        int rises;
        reset = 1'b1; enable = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
        res_in = '0; mode_in = '0;
        repeat (3) @(negedge clk);
        chk("rst/in_ready", ir16, 1);
        chk("rst/out_valid", ov16, 0);
        chk("rst/mode_out", mo16, 0);
        for (int k = 0; k < 16; k++) chk("rst/coeff", $signed(co16[k]), 0);
        reset = 1'b0;
        @(negedge clk);

        run_block(fill(0), 5, 0, 0, "zeros");
        run_block(fill(1), 1, 0, 1, "ones");
        x = fill(0); x[0] = 1;
        run_block(x, 2, 0, 0, "impulse");
        run_block(fill(-128), 3, 0, 0, "min");
        run_block(fill(127), 4, 3, 5, "max_stall");
        for (int n = 0; n < 25; n++)
            run_block(rand_blk(), int'($urandom_range(0, 7)),
                      int'($urandom_range(0, 3)), int'($urandom_range(0, 4)), "rand");

        // Reset in the middle of the column pass discards the block.
        x = rand_blk(); x[0] = 77;
        present(x, 6);
        repeat (6) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        chk("midrst/out_valid", ov16, 0);
        chk("midrst/in_ready", ir16, 1);
        chk("midrst/mode_out", mo16, 0);
        for (int k = 0; k < 16; k++) chk("midrst/coeff", $signed(co16[k]), 0);
        rises = 0;
        repeat (12) begin
            @(negedge clk);
            if (ov16) rises++;
        end
        chk("midrst/no_output", rises, 0);

        run_block(rand_blk(), 7, 1, 2, "after_rst");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog obs=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end

endmodule
